// File: rtl/musicbox_pkg.sv
// Shared definitions for the music box state machines: state codes,
// recording-memory entry layout and the recorder FSM encoding.
package musicbox_pkg;

  // State codes driven by the state controller on currentState.
  localparam logic [4:0] STATE_DO_NOTHING     = 5'd0;
  localparam logic [4:0] STATE_PLAY_RECORDING = 5'd1;
  localparam logic [4:0] STATE_MAKE_RECORDING = 5'd2;

  // Default field widths of one recording entry.
  localparam int NOTE_W_DEF = 5;
  localparam int RUN_W_DEF  = 11;

  // One recording entry: a note held for run_len milliseconds.
  typedef struct packed {
    logic [NOTE_W_DEF-1:0] note;
    logic [RUN_W_DEF-1:0]  run_len;
  } entry_t;

  // A zero-length silence entry marks the end of a recording.
  localparam entry_t TERMINATOR = '0;

  // Recorder FSM encoding.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RECORD    = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_WRITE_END = 3'd3,
    ST_DONE      = 3'd4
  } rec_state_e;

endpackage

// File: rtl/musicbox_rle_write_buffer.sv
// One-entry pending write register in front of the recording memory.
// Handshake: an entry is transferred on every cycle where o_wr_en and
// i_mem_ready are both high; o_wr_addr/o_wr_data hold steady until then.
// A push while the slot is occupied (and not leaving this cycle) is dropped
// and sets the sticky overflow flag.
module musicbox_rle_write_buffer
  import musicbox_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_mem_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_accept,
  output logic              o_full_next,
  output logic              o_busy,
  output logic              o_overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PRE_LAST  = LAST_ADDR - ADDR_ONE;

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_overflow;
  logic              w_accept;
  logic              w_slot_free;

  assign w_accept    = r_valid && i_mem_ready;
  assign w_slot_free = !r_valid || w_accept;

  assign o_wr_en     = r_valid;
  assign o_wr_addr   = r_addr;
  assign o_wr_data   = r_data;
  assign o_accept    = w_accept;
  // The write being accepted now leaves only the terminator slot free.
  assign o_full_next = w_accept && (r_addr == PRE_LAST);
  assign o_busy      = r_valid;
  assign o_overflow  = r_overflow;

  // Pending slot, address counter and overflow flag; the address stops at
  // the last location so it never wraps back over the recording.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_push) begin
        if (w_slot_free) begin
          r_valid <= 1'b1;
          r_data  <= i_push_data;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_accept && (r_addr != LAST_ADDR)) begin
        r_addr <= r_addr + ADDR_ONE;
      end
    end
  end

endmodule

// File: rtl/musicbox_state_make_recording.sv
// Recording state of the music box: samples the user note every 1 kHz tick,
// run-length encodes it into {note, run_len} entries, writes them to the
// recording memory and closes the recording with a {0,0} terminator.
module musicbox_state_make_recording
  import musicbox_pkg::*;
#(
  parameter logic [4:0] STATE_ID = STATE_MAKE_RECORDING,
  parameter int         MAX_MS   = 5000,
  parameter int         ADDR_W   = 10,
  parameter int         NOTE_W   = NOTE_W_DEF,
  parameter int         RUN_W    = RUN_W_DEF
) (
  input  logic                    clock_50Mhz,
  input  logic                    reset,
  input  logic [4:0]              currentState,
  input  logic                    tick_1khz,
  input  logic [NOTE_W-1:0]       note_in,
  input  logic                    stop_request,
  output logic                    mem_wr_en,
  output logic [ADDR_W-1:0]       mem_wr_addr,
  output logic [NOTE_W+RUN_W-1:0] mem_wr_data,
  input  logic                    mem_wr_ready,
  output logic [ADDR_W:0]         record_length,
  output logic                    stateComplete,
  output logic [31:0]             debugString
);

  localparam int                ENTRY_W  = NOTE_W + RUN_W;
  localparam logic [RUN_W-1:0]  RUN_MAX  = '1;
  localparam logic [RUN_W-1:0]  RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [15:0]       MAX_MS_C = 16'(MAX_MS);

  rec_state_e          r_state;
  logic [NOTE_W-1:0]   r_run_note;
  logic [RUN_W-1:0]    r_run_len;
  logic [15:0]         r_ms_count;
  logic [ADDR_W:0]     r_record_length;

  logic                w_active;
  logic                w_extend;
  logic [15:0]         w_ms_next;
  logic                w_push;
  logic [ENTRY_W-1:0]  w_push_data;
  logic                w_clear;
  logic                w_accept;
  logic                w_full_next;
  logic                w_busy;
  logic                w_overflow;
  logic [ADDR_W-1:0]   w_addr;
  logic [10:0]         w_addr_ext;

  assign w_active  = (currentState == STATE_ID);
  assign w_extend  = (note_in == r_run_note) && (r_run_len != RUN_MAX);
  assign w_ms_next = (r_ms_count != MAX_MS_C) ? r_ms_count + 16'd1 : r_ms_count;

  // Decide what (if anything) goes into the pending write slot this cycle.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = {r_run_note, r_run_len};
    w_clear     = 1'b0;
    if ((r_state != ST_IDLE) && !w_active) begin
      w_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_clear = w_active;
        end
        ST_RECORD: begin
          if (w_full_next) begin
            w_push      = 1'b1;
            w_push_data = '0;
          end else if (tick_1khz && !w_extend && (r_run_len != '0)) begin
            w_push = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (w_full_next) begin
            w_push      = 1'b1;
            w_push_data = '0;
          end else if (!w_busy) begin
            w_push = 1'b1;
            if (r_run_len == '0) w_push_data = '0;
          end
        end
        default: begin
          w_push = 1'b0;
        end
      endcase
    end
  end

  musicbox_rle_write_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (ENTRY_W)
  ) u_wbuf (
    .i_clk       (clock_50Mhz),
    .i_rst       (reset),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_mem_ready (mem_wr_ready),
    .o_wr_en     (mem_wr_en),
    .o_wr_addr   (w_addr),
    .o_wr_data   (mem_wr_data),
    .o_accept    (w_accept),
    .o_full_next (w_full_next),
    .o_busy      (w_busy),
    .o_overflow  (w_overflow)
  );

  // FSM and run accounting; leaving STATE_ID aborts from any active state.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_run_note      <= '0;
      r_run_len       <= '0;
      r_ms_count      <= '0;
      r_record_length <= '0;
    end else if ((r_state != ST_IDLE) && !w_active) begin
      r_state <= ST_IDLE;
      if (r_state != ST_DONE) r_record_length <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_active) begin
            r_run_note      <= note_in;
            r_run_len       <= '0;
            r_ms_count      <= '0;
            r_record_length <= '0;
            r_state         <= ST_RECORD;
          end
        end
        ST_RECORD: begin
          if (w_full_next) begin
            r_state <= ST_WRITE_END;
          end else begin
            if (tick_1khz) begin
              r_ms_count <= w_ms_next;
              if (w_extend) begin
                r_run_len <= r_run_len + RUN_ONE;
              end else begin
                r_run_note <= note_in;
                r_run_len  <= RUN_ONE;
              end
            end
            if ((tick_1khz && (w_ms_next == MAX_MS_C)) || stop_request) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (w_full_next) begin
            r_state <= ST_WRITE_END;
          end else if (!w_busy) begin
            if (r_run_len != '0) r_run_len <= '0;
            else                 r_state   <= ST_WRITE_END;
          end
        end
        ST_WRITE_END: begin
          if (w_accept) begin
            r_record_length <= {1'b0, w_addr} + LEN_ONE;
            r_state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_addr_ext    = 11'(w_addr);
  assign mem_wr_addr   = w_addr;
  assign record_length = r_record_length;
  assign stateComplete = (r_state == ST_DONE);
  assign debugString   = {w_overflow, 4'b0000, w_addr_ext, r_ms_count};

endmodule
